// File: rtl/ysyx_23060240_clint_pkg.sv
// Shared definitions for the CLINT mtime responder: register offsets and
// the read/write handshake FSM state types.
package ysyx_23060240_clint_pkg;

  localparam logic [31:0] CLINT_OFF_LO = 32'h0;
  localparam logic [31:0] CLINT_OFF_HI = 32'h4;

  typedef enum logic {R_IDLE, R_RESP} rd_state_e;
  typedef enum logic {W_IDLE, W_RESP} wr_state_e;

endpackage

// File: rtl/ysyx_23060240_clint_timer.sv
// Free-running 64-bit mtime counter behind a TICK_DIV prescaler, with
// per-word load that overrides the increment in the load cycle.
module ysyx_23060240_clint_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_lo,
  input  logic        ld_hi,
  input  logic [31:0] ld_data,
  output logic [63:0] mtime
);

  logic [31:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic        tick;

  assign tick  = (presc_q == 32'(TICK_DIV - 1));
  assign mtime = mtime_q;

  always_comb begin
    presc_d = tick ? 32'd0 : presc_q + 32'd1;
    mtime_d = mtime_q;
    // A load wins over the tick; the prescaler keeps running regardless.
    if (ld_lo) begin
      mtime_d[31:0] = ld_data;
    end else if (ld_hi) begin
      mtime_d[63:32] = ld_data;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

endmodule

// File: rtl/ysyx_23060240_clint.sv
// AXI4-Lite single-beat responder exposing mtime as two 32-bit words, with a
// hi-word snapshot taken on every LO read so LO-then-HI reads are coherent.
module ysyx_23060240_clint
  import ysyx_23060240_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'ha0000048,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic        wvalid,
  output logic        wready,
  output logic        bvalid,
  input  logic        bready
);

  localparam logic [31:0] ADDR_LO = BASE_ADDR + CLINT_OFF_LO;
  localparam logic [31:0] ADDR_HI = BASE_ADDR + CLINT_OFF_HI;

  rd_state_e   rd_state_q, rd_state_d;
  wr_state_e   wr_state_q, wr_state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] shadow_q, shadow_d;
  logic        shadow_vld_q, shadow_vld_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [63:0] mtime;
  logic        aw_fire, w_fire, wr_commit, ld_lo, ld_hi;
  logic [31:0] wr_addr, wr_data;

  assign arready = (rd_state_q == R_IDLE);
  assign rvalid  = (rd_state_q == R_RESP);
  assign rdata   = rdata_q;
  assign awready = (wr_state_q == W_IDLE) && !aw_held_q;
  assign wready  = (wr_state_q == W_IDLE) && !w_held_q;
  assign bvalid  = (wr_state_q == W_RESP);

  // AW and W may arrive in either order; use the held copy when present.
  assign aw_fire   = awvalid && awready;
  assign w_fire    = wvalid && wready;
  assign wr_addr   = aw_held_q ? awaddr_q : awaddr;
  assign wr_data   = w_held_q ? wdata_q : wdata;
  assign wr_commit = (aw_held_q || aw_fire) && (w_held_q || w_fire);
  assign ld_lo     = wr_commit && (wr_addr == ADDR_LO);
  assign ld_hi     = wr_commit && (wr_addr == ADDR_HI);

  always_comb begin
    rd_state_d   = rd_state_q;
    rdata_d      = rdata_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (arvalid) begin
          rd_state_d = R_RESP;
          if (araddr == ADDR_LO) begin
            rdata_d      = mtime[31:0];
            shadow_d     = mtime[63:32];
            shadow_vld_d = 1'b1;
          end else if (araddr == ADDR_HI) begin
            rdata_d      = shadow_vld_q ? shadow_q : mtime[63:32];
            shadow_vld_d = 1'b0;
          end else begin
            rdata_d = '0;
          end
        end
      end
      R_RESP: begin
        if (rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
    // A write invalidates any snapshot, including one taken this same cycle.
    if (wr_commit) shadow_vld_d = 1'b0;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
        end
        if (w_fire) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
        end
        if (wr_commit) begin
          wr_state_d = W_RESP;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
      W_RESP: begin
        if (bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q   <= R_IDLE;
      wr_state_q   <= W_IDLE;
      rdata_q      <= '0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      aw_held_q    <= 1'b0;
      w_held_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
    end else begin
      rd_state_q   <= rd_state_d;
      wr_state_q   <= wr_state_d;
      rdata_q      <= rdata_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      aw_held_q    <= aw_held_d;
      w_held_q     <= w_held_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
    end
  end

  ysyx_23060240_clint_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .ld_lo  (ld_lo),
    .ld_hi  (ld_hi),
    .ld_data(wr_data),
    .mtime  (mtime)
  );

endmodule

// File: tb/tb_ysyx_23060240_clint.sv
// Scoreboard bench for the CLINT: read expectations come from a cycle model of
// mtime and the hi-word snapshot, pushed at AR accept and popped on R handshake.
module tb_ysyx_23060240_clint;

  localparam logic [31:0] BASE = 32'ha0000048;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  logic [63:0] mdl;
  logic        mdl_ld_lo, mdl_ld_hi;
  logic [31:0] mdl_ld_data;
  logic [31:0] mdl_shadow;
  logic        mdl_shvld;

  always #5 clk = ~clk;

  ysyx_23060240_clint #(
    .BASE_ADDR(BASE),
    .TICK_DIV (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .araddr (araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rvalid (rvalid),
    .rready (rready),
    .rdata  (rdata),
    .awaddr (awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wvalid (wvalid),
    .wready (wready),
    .bvalid (bvalid),
    .bready (bready)
  );

  // Reference mtime: +1 every cycle unless the bench scheduled a word load.
  always @(posedge clk or posedge rst) begin
    if (rst) mdl <= '0;
    else if (mdl_ld_lo) mdl <= {mdl[63:32], mdl_ld_data};
    else if (mdl_ld_hi) mdl <= {mdl_ld_data, mdl[31:0]};
    else mdl <= mdl + 64'd1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rvalid && rready) begin
      check_eq("rd_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check_eq("rdata", 64'(rdata), 64'(exp_q.pop_front()));
    end
  end

  task automatic do_read(input logic [31:0] addr);
    logic [31:0] e;
    int n;
    @(posedge clk); #1;
    arvalid = 1'b1;
    araddr  = addr;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("ar_accept", 64'(arready), 64'd1);
    if (addr == BASE) begin
      e          = mdl[31:0];
      mdl_shadow = mdl[63:32];
      mdl_shvld  = 1'b1;
    end else if (addr == BASE + 32'd4) begin
      e         = mdl_shvld ? mdl_shadow : mdl[63:32];
      mdl_shvld = 1'b0;
    end else begin
      e = 32'h0;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    awvalid = 1'b1;
    awaddr  = addr;
    wvalid  = 1'b1;
    wdata   = data;
    @(negedge clk);
    check_eq("aw_ready", 64'(awready), 64'd1);
    check_eq("w_ready", 64'(wready), 64'd1);
    mdl_ld_lo   = (addr == BASE);
    mdl_ld_hi   = (addr == BASE + 32'd4);
    mdl_ld_data = data;
    mdl_shvld   = 1'b0;
    @(posedge clk); #1;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    mdl_ld_lo = 1'b0;
    mdl_ld_hi = 1'b0;
    @(negedge clk);
    check_eq("bvalid_rise", 64'(bvalid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("bvalid_fall", 64'(bvalid), 64'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b1;
    mdl_ld_lo = 1'b0; mdl_ld_hi = 1'b0; mdl_ld_data = '0;
    mdl_shadow = '0; mdl_shvld = 1'b0;
    #1;
    check_eq("rst_arready", 64'(arready), 64'd1);
    check_eq("rst_awready", 64'(awready), 64'd1);
    check_eq("rst_wready", 64'(wready), 64'd1);
    check_eq("rst_rvalid", 64'(rvalid), 64'd0);
    check_eq("rst_bvalid", 64'(bvalid), 64'd0);
    check_eq("rst_rdata", 64'(rdata), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle count from reset.
    repeat (10) @(posedge clk);
    do_read(BASE);
    wait_drain();

    // Snapshot: hi carries over between LO and HI reads, HI returns the shadow.
    do_write(BASE + 32'd4, 32'h0);
    do_write(BASE, 32'hFFFF_FFFC);
    do_read(BASE);
    repeat (5) @(posedge clk);
    do_read(BASE + 32'd4);
    do_read(BASE + 32'd4);
    wait_drain();

    // 64-bit wrap.
    do_write(BASE + 32'd4, 32'hFFFF_FFFF);
    do_write(BASE, 32'hFFFF_FFFF);
    do_read(BASE);
    do_read(BASE + 32'd4);
    wait_drain();

    // W ahead of AW; mtime must stay untouched until AW arrives.
    @(posedge clk); #1;
    wvalid = 1'b1;
    wdata  = 32'h1234_5678;
    @(negedge clk);
    check_eq("w_first_ready", 64'(wready), 64'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(negedge clk);
    check_eq("w_held_wready", 64'(wready), 64'd0);
    check_eq("w_held_bvalid", 64'(bvalid), 64'd0);
    do_read(BASE);
    @(negedge clk);
    check_eq("w_held_wready2", 64'(wready), 64'd0);
    check_eq("w_held_bvalid2", 64'(bvalid), 64'd0);
    @(posedge clk); #1;
    awvalid = 1'b1;
    awaddr  = BASE + 32'd4;
    @(negedge clk);
    check_eq("aw_late_ready", 64'(awready), 64'd1);
    mdl_ld_hi   = 1'b1;
    mdl_ld_data = 32'h1234_5678;
    mdl_shvld   = 1'b0;
    @(posedge clk); #1;
    awvalid   = 1'b0;
    mdl_ld_hi = 1'b0;
    @(negedge clk);
    check_eq("aw_late_bvalid", 64'(bvalid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("aw_late_bdone", 64'(bvalid), 64'd0);
    check_eq("aw_late_wready", 64'(wready), 64'd1);
    check_eq("aw_late_awready", 64'(awready), 64'd1);
    do_read(BASE);
    do_read(BASE + 32'd4);
    wait_drain();

    // R channel stall: response held stable.
    rready = 1'b0;
    do_read(BASE);
    repeat (4) begin
      @(negedge clk);
      check_eq("stall_rvalid", 64'(rvalid), 64'd1);
      check_eq("stall_arready", 64'(arready), 64'd0);
      check_eq("stall_have_exp", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check_eq("stall_rdata", 64'(rdata), 64'(exp_q[0]));
    end
    @(posedge clk); #1;
    rready = 1'b1;
    wait_drain();

    // Unmapped read and write.
    do_read(BASE + 32'd8);
    do_write(BASE + 32'd12, 32'hDEAD_BEEF);
    do_read(BASE);
    do_read(BASE + 32'd4);
    wait_drain();

    // Asynchronous reset while a write response is stalled.
    bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b1;
    awaddr  = BASE;
    wvalid  = 1'b1;
    wdata   = 32'h0000_0005;
    @(negedge clk);
    mdl_ld_lo   = 1'b1;
    mdl_ld_data = 32'h0000_0005;
    mdl_shvld   = 1'b0;
    @(posedge clk); #1;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    mdl_ld_lo = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("bstall_bvalid", 64'(bvalid), 64'd1);
    end
    #2 rst = 1'b1;
    mdl_shvld = 1'b0;
    #1;
    check_eq("arst_bvalid", 64'(bvalid), 64'd0);
    check_eq("arst_awready", 64'(awready), 64'd1);
    check_eq("arst_wready", 64'(wready), 64'd1);
    check_eq("arst_arready", 64'(arready), 64'd1);
    @(posedge clk); #1;
    rst    = 1'b0;
    bready = 1'b1;
    @(negedge clk);
    check_eq("post_rst_bvalid", 64'(bvalid), 64'd0);
    do_read(BASE);
    do_read(BASE + 32'd4);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
